seven_seg_scan: RTL and testbench
=================================

Name: seven_seg_scan

Overview:
- Drives the two-digit multiplexed seven-segment display from the output selector's nibble pair {OUT2, OUT1}.
- Snapshots both nibbles once per frame, so a digit pair never shows a torn value.
- Scans the two digits with a programmable dwell time and an all-off gap between digits to suppress ghosting.
- Converts each nibble to active-low hex glyphs. Optionally blanks a leading zero on the high digit.

Parameters:
- REFRESH_DIV, 50000, CLK cycles each digit is lit (1 ms at 50 MHz); must be >= 1.
- GAP_CYCLES, 500, CLK cycles with all digits off after each digit; 0 means the gap states are skipped.
- CNT_W, 16, width of the dwell/gap counter; must hold max(REFRESH_DIV, GAP_CYCLES)-1.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- ENABLE  in  1  1 = scan; 0 = display dark and frame restarts.
- BLANK_LZ  in  1  1 = blank the high digit when its snapshot nibble is 0.
- OUT1  in  4  low nibble from the output selector; shown on digit 0.
- OUT2  in  4  high nibble from the output selector; shown on digit 1.
- SEG  out  8  active-low segments {dp,g,f,e,d,c,b,a}; dp is always 1 (off).
- DIGIT  out  2  active-low anodes; bit0 = digit 0, bit1 = digit 1.
- FRAME  out  1  one-cycle pulse on the first cycle of each frame.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- On reset assertion, immediately:
  - state = S_GAP1, cnt = 0, snap = 8'h00;
  - SEG = 8'hFF, DIGIT = 2'b11, FRAME = 0.
- FSM states: S_DIG0 -> S_GAP0 -> S_DIG1 -> S_GAP1 -> S_DIG0.
  - S_DIGx lasts REFRESH_DIV cycles.
  - S_GAPx lasts GAP_CYCLES cycles.
  - If GAP_CYCLES = 0, S_DIG0 goes to S_DIG1 and S_DIG1 goes to S_DIG0.
- cnt runs 0..len-1 within each state and clears on every state change.
- Frame period is 2*(REFRESH_DIV+GAP_CYCLES) cycles.
- Snapshot: on the edge that enters S_DIG0, snap <= {OUT2, OUT1}. Changes to OUT1/OUT2 at any other time have no visible effect until the next frame.
- FRAME is 1 exactly during the first cycle of S_DIG0.
- Outputs are registered and computed from the next state, so they are valid in the same cycles as the state, with no extra latency:
  - S_DIG0: DIGIT = 2'b10, SEG = enc(snap[3:0]).
  - S_DIG1: DIGIT = 2'b01, SEG = enc(snap[7:4]); if BLANK_LZ = 1 and snap[7:4] = 0, DIGIT = 2'b11 and SEG = 8'hFF.
  - S_GAPx: DIGIT = 2'b11, SEG = 8'hFF.
- enc(0..F) = C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E (hex).
- BLANK_LZ is sampled live during S_DIG1.
- ENABLE:
  - ENABLE = 0 forces state = S_GAP1, cnt = 0, and dark outputs on the next edge. It holds them there while low; snap keeps its value.
  - After ENABLE rises, the first S_DIG0 (with a new snapshot) is entered after GAP_CYCLES cycles, or on the next edge if GAP_CYCLES = 0.
  - ENABLE dropping mid-digit darkens the display within 1 cycle.
- Reset mid-frame aborts the scan immediately; the display is dark until the first S_DIG0 after release.
- Exactly one digit is ever low on DIGIT. DIGIT = 2'b00 is illegal (bench assertion).

Decomposition:
- Shared package seven_seg_pkg holds:
  - the 16-entry glyph constant array (active-low);
  - SEG_OFF = 8'hFF and DIG_OFF = 2'b11;
  - the state encoding: S_DIG0 = 0, S_GAP0 = 1, S_DIG1 = 2, S_GAP1 = 3.
- One sub-module, hex_to_seg: 4-bit in, 8-bit active-low glyph out, purely combinational. It is instantiated twice (or muxed once) ahead of the SEG register.
- FSM, counter and snapshot register stay in seven_seg_scan.

Test Plan (bench uses REFRESH_DIV = 4, GAP_CYCLES = 2, CNT_W = 4):
1. Reset, then ENABLE = 1 with OUT2/OUT1 = 3/A.
   - After 2 gap cycles, FRAME pulses once.
   - DIGIT = 10 and SEG = 88 for 4 cycles; then 11/FF for 2 cycles; then DIGIT = 01 and SEG = B0 for 4 cycles; then 11/FF for 2 cycles.
   - The next FRAME comes 12 cycles after the first.
2. Change OUT1 from A to 5 during S_DIG1.
   - Digit 0 stays 88 until the next frame, then shows 92.
3. BLANK_LZ = 1 with OUT2 = 0, OUT1 = 7.
   - Digit 0 shows F8.
   - During S_DIG1, DIGIT = 11 and SEG = FF.
   - With OUT2 = 1 on a later frame, digit 1 shows F9.
4. Drop ENABLE in the 2nd cycle of S_DIG0.
   - DIGIT = 11 and SEG = FF on the next edge, held while ENABLE is low.
   - After re-enable, FRAME comes 2 cycles later with a new snapshot.
5. Pulse RESET asynchronously mid-S_DIG1, between clock edges.
   - Outputs go to 11/FF before the next clock edge and snap = 00.
   - After release, the first FRAME is 2 cycles later.
6. Re-instance with GAP_CYCLES = 0 and sweep OUT1 over 0..F.
   - No gap states; digits alternate every 4 cycles.
   - SEG matches the glyph table for all 16 values.
   - DIGIT is never 00 (assertion).

Source files
------------

// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared glyph table, dark constants and scan state encoding
package seven_seg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [1:0] DIG_OFF = 2'b11;

    // Active-low {dp,g,f,e,d,c,b,a}; dp stays off in every glyph.
    localparam logic [7:0] GLYPH [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef enum logic [1:0] {
        S_DIG0 = 2'd0,
        S_GAP0 = 2'd1,
        S_DIG1 = 2'd2,
        S_GAP1 = 2'd3
    } state_t;

endpackage

// File: rtl/seven_seg_scan_if.sv
// rtl/seven_seg_scan_if.sv - nibble inputs, scan controls and display outputs of the scanner
interface seven_seg_scan_if;
    logic       enable;
    logic       blank_lz;
    logic [3:0] out1;
    logic [3:0] out2;
    logic [7:0] seg;
    logic [1:0] digit;
    logic       frame;

    modport master (output enable, blank_lz, out1, out2, input seg, digit, frame);
    modport slave  (input enable, blank_lz, out1, out2, output seg, digit, frame);
endinterface

// File: rtl/seven_seg_scan_hex_to_seg.sv
// rtl/seven_seg_scan_hex_to_seg.sv - combinational nibble to active-low hex glyph
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);
    assign seg = GLYPH[nibble];
endmodule

// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - two-digit multiplexed display scanner with per-frame snapshot and ghosting gap
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int GAP_CYCLES  = 500,
    parameter int CNT_W       = 16
) (
    input logic          clk,
    input logic          rst,
    seven_seg_scan_if.slave bus
);
    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [7:0]         snap, snap_n;
    logic [7:0]         seg_n;
    logic [1:0]         digit_n;
    logic               frame_n;
    logic               enter0;
    logic               done;
    logic [31:0]        len;
    logic [3:0]         nib;
    logic [7:0]         glyph;

    hex_to_seg u_enc (.nibble(nib), .seg(glyph));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_GAP1;
            cnt       <= '0;
            snap      <= 8'h00;
            bus.seg   <= SEG_OFF;
            bus.digit <= DIG_OFF;
            bus.frame <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            snap      <= snap_n;
            bus.seg   <= seg_n;
            bus.digit <= digit_n;
            bus.frame <= frame_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CNT_W'(1);
        len     = (state == S_DIG0 || state == S_DIG1) ? 32'(REFRESH_DIV) : 32'(GAP_CYCLES);
        // A zero-length gap counts as already finished, so it is skipped on the next edge.
        done    = (32'(cnt) + 32'd1 >= len);

        if (!bus.enable) begin
            state_n = S_GAP1;
            cnt_n   = '0;
        end else if (done) begin
            cnt_n = '0;
            case (state)
                S_DIG0:  state_n = (GAP_CYCLES == 0) ? S_DIG1 : S_GAP0;
                S_GAP0:  state_n = S_DIG1;
                S_DIG1:  state_n = (GAP_CYCLES == 0) ? S_DIG0 : S_GAP1;
                default: state_n = S_DIG0;
            endcase
        end

        enter0  = (state_n == S_DIG0) && (state != S_DIG0);
        snap_n  = enter0 ? {bus.out2, bus.out1} : snap;
        frame_n = enter0;
        nib     = (state_n == S_DIG0) ? snap_n[3:0] : snap_n[7:4];

        seg_n   = SEG_OFF;
        digit_n = DIG_OFF;
        case (state_n)
            S_DIG0: begin
                seg_n   = glyph;
                digit_n = 2'b10;
            end
            S_DIG1: begin
                if (!(bus.blank_lz && snap_n[7:4] == 4'h0)) begin
                    seg_n   = glyph;
                    digit_n = 2'b01;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb/tb_seven_seg_scan.sv - directed self-checking bench for seven_seg_scan
module tb_seven_seg_scan;
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    logic [7:0] exp_glyph [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    seven_seg_scan_if if_a ();
    seven_seg_scan_if if_b ();

    seven_seg_scan #(.REFRESH_DIV(4), .GAP_CYCLES(2), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst_a), .bus(if_a.slave)
    );
    seven_seg_scan #(.REFRESH_DIV(4), .GAP_CYCLES(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst_b), .bus(if_b.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        n_assert++;
        assert (if_a.digit !== 2'b00 && if_b.digit !== 2'b00) else begin
            n_fail++;
            $error("FAIL digit_never_00: observed a=%b b=%b expected not 00", if_a.digit, if_b.digit);
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic run(input bit b, input int n, input logic [1:0] d, input logic [7:0] s,
                       input bit f, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s[%0d].digit", tag, i), {6'b0, b ? if_b.digit : if_a.digit}, {6'b0, d});
            chk($sformatf("%s[%0d].seg", tag, i), b ? if_b.seg : if_a.seg, s);
            chk($sformatf("%s[%0d].frame", tag, i), {7'b0, b ? if_b.frame : if_a.frame},
                {7'b0, (i == 0) ? f : 1'b0});
        end
    endtask

    initial begin
        if_a.enable = 1'b0; if_a.blank_lz = 1'b0; if_a.out1 = 4'h0; if_a.out2 = 4'h0;
        if_b.enable = 1'b0; if_b.blank_lz = 1'b0; if_b.out1 = 4'h0; if_b.out2 = 4'h0;

        // Reset state
        @(posedge clk); #1;
        chk("reset.digit", {6'b0, if_a.digit}, 8'h03);
        chk("reset.seg", if_a.seg, 8'hFF);
        chk("reset.frame", {7'b0, if_a.frame}, 8'h00);
        chk("reset.snap", dut_a.snap, 8'h00);
        @(posedge clk); #1;
        rst_a = 1'b0;
        if_a.enable = 1'b1; if_a.out2 = 4'h3; if_a.out1 = 4'hA;

        // 1: basic frame
        run(0, 1, 2'b11, 8'hFF, 0, "t1.gap_in");
        run(0, 4, 2'b10, 8'h88, 1, "t1.dig0");
        run(0, 2, 2'b11, 8'hFF, 0, "t1.gap0");
        run(0, 4, 2'b01, 8'hB0, 0, "t1.dig1");
        run(0, 2, 2'b11, 8'hFF, 0, "t1.gap1");
        run(0, 4, 2'b10, 8'h88, 1, "t1.dig0_f2");

        // 2: input change mid-frame is deferred to next frame
        run(0, 2, 2'b11, 8'hFF, 0, "t2.gap0");
        run(0, 1, 2'b01, 8'hB0, 0, "t2.dig1a");
        if_a.out1 = 4'h5;
        run(0, 3, 2'b01, 8'hB0, 0, "t2.dig1b");
        run(0, 2, 2'b11, 8'hFF, 0, "t2.gap1");
        run(0, 4, 2'b10, 8'h92, 1, "t2.dig0");

        // 3: leading-zero blanking
        if_a.blank_lz = 1'b1; if_a.out2 = 4'h0; if_a.out1 = 4'h7;
        run(0, 2, 2'b11, 8'hFF, 0, "t3.gap0a");
        run(0, 4, 2'b01, 8'hB0, 0, "t3.dig1_old");
        run(0, 2, 2'b11, 8'hFF, 0, "t3.gap1a");
        run(0, 4, 2'b10, 8'hF8, 1, "t3.dig0");
        run(0, 2, 2'b11, 8'hFF, 0, "t3.gap0b");
        run(0, 4, 2'b11, 8'hFF, 0, "t3.dig1_blank");
        if_a.out2 = 4'h1;
        run(0, 2, 2'b11, 8'hFF, 0, "t3.gap1b");
        run(0, 4, 2'b10, 8'hF8, 1, "t3.dig0b");
        run(0, 2, 2'b11, 8'hFF, 0, "t3.gap0c");
        run(0, 4, 2'b01, 8'hF9, 0, "t3.dig1_one");
        run(0, 2, 2'b11, 8'hFF, 0, "t3.gap1c");

        // 4: enable drop in 2nd cycle of digit 0
        if_a.blank_lz = 1'b0;
        run(0, 1, 2'b10, 8'hF8, 1, "t4.dig0_c1");
        run(0, 1, 2'b10, 8'hF8, 0, "t4.dig0_c2");
        if_a.enable = 1'b0;
        run(0, 3, 2'b11, 8'hFF, 0, "t4.disabled");
        if_a.enable = 1'b1; if_a.out2 = 4'h2; if_a.out1 = 4'hC;
        run(0, 1, 2'b11, 8'hFF, 0, "t4.gap_in");
        run(0, 4, 2'b10, 8'hC6, 1, "t4.dig0_new");
        run(0, 2, 2'b11, 8'hFF, 0, "t4.gap0");
        run(0, 1, 2'b01, 8'hA4, 0, "t4.dig1");

        // 5: asynchronous reset between edges
        #2;
        rst_a = 1'b1;
        #1;
        chk("t5.async.digit", {6'b0, if_a.digit}, 8'h03);
        chk("t5.async.seg", if_a.seg, 8'hFF);
        chk("t5.async.frame", {7'b0, if_a.frame}, 8'h00);
        chk("t5.async.snap", dut_a.snap, 8'h00);
        #1;
        rst_a = 1'b0;
        run(0, 1, 2'b11, 8'hFF, 0, "t5.gap_in");
        run(0, 4, 2'b10, 8'hC6, 1, "t5.dig0");

        // 6: no-gap instance, full glyph sweep
        rst_b = 1'b0;
        if_b.enable = 1'b1;
        for (int v = 0; v < 16; v++) begin
            if_b.out1 = 4'(v);
            run(1, 4, 2'b10, exp_glyph[v], 1, $sformatf("t6.dig0_%0h", v));
            run(1, 4, 2'b01, 8'hC0, 0, $sformatf("t6.dig1_%0h", v));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
